// File: rtl/magic_grid_loader_pkg.sv
// Shared constants and types for the magic-square grid loader.
package magic_pkg;

  // Number of cells in a 3x3 grid and the largest legal BCD digit.
  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Loader phases: collecting digits, offering the grid, holding the verdict.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } loader_state_t;

  // True when the digit is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_t d);
    return (d <= MAX_DIGIT);
  endfunction

  // One-hot position of a digit value inside the 10-bit seen mask.
  // Values above 9 shift out of range and yield an all-zero vector.
  function automatic logic [9:0] digit_onehot(input bcd_t d);
    return 10'(1) << d;
  endfunction

endpackage

// File: rtl/magic_grid_loader_digit_seen_tracker.sv
// Remembers which digit values have been accepted into the grid and raises
// a sticky flag the first time an accepted value repeats an earlier one.
module digit_seen_tracker
  import magic_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic accept,
  input  bcd_t digit,
  output logic dup_seen
);

  logic [9:0] seen_mask;
  logic [9:0] digit_bit;
  logic       repeat_hit;

  // Decode the offered digit and test it against the values already taken.
  always_comb begin
    digit_bit  = digit_onehot(digit);
    repeat_hit = |(seen_mask & digit_bit);
  end

  // Seen mask and sticky duplicate flag; clear empties both for a new grid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_mask <= '0;
      dup_seen  <= 1'b0;
    end else if (clear) begin
      seen_mask <= '0;
      dup_seen  <= 1'b0;
    end else if (accept) begin
      seen_mask <= seen_mask | digit_bit;
      if (repeat_hit) begin
        dup_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/magic_grid_loader.sv
// Sequential front end for the 3x3 magic-square checker: collects nine BCD
// digits over valid/ready, presents them in parallel, and captures the
// checker's verdict and two-digit sum.
module magic_grid_loader
  import magic_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [3:0] num5,
  output logic [3:0] num6,
  output logic [3:0] num7,
  output logic [3:0] num8,
  output logic [3:0] num9,
  output logic [3:0] cell_idx,
  output logic       grid_valid,
  input  logic       grid_ack,
  input  logic       it_is_magic,
  input  logic [3:0] sum1,
  input  logic [3:0] sum2,
  output logic       result_valid,
  output logic       magic,
  output logic [3:0] sum_tens,
  output logic [3:0] sum_ones,
  output logic       bad_digit,
  output logic       dup_seen
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CELLS - 1);

  loader_state_t state;
  loader_state_t next_state;

  bcd_t cells [NUM_CELLS];

  logic accept;
  logic store;
  logic reject;
  logic take_ack;

  // Handshake qualification; clear discards whatever arrives with it.
  always_comb begin
    accept   = digit_valid && digit_ready;
    store    = accept && is_bcd(digit_in) && !clear;
    reject   = accept && !is_bcd(digit_in) && !clear;
    take_ack = (state == PRESENT) && grid_ack && !clear;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: fill nine cells, wait for the ack, then hold until clear.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (store && (cell_idx == LAST_IDX)) begin
            next_state = PRESENT;
          end
        end
        PRESENT: begin
          if (take_ack) begin
            next_state = DONE;
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = LOAD;
        end
      endcase
    end
  end

  // Output decode: the loader only takes digits while collecting.
  always_comb begin
    digit_ready = (state == LOAD);
  end

  // Phase flags registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grid_valid   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      grid_valid   <= (next_state == PRESENT);
      result_valid <= (next_state == DONE);
    end
  end

  // Cell write pointer; it reaches 9 once the grid is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cell_idx <= '0;
    end else if (clear) begin
      cell_idx <= '0;
    end else if (store) begin
      cell_idx <= cell_idx + 4'd1;
    end
  end

  // Cell registers, written in row-major order and frozen outside LOAD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells[i] <= '0;
      end
    end else if (store) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (cell_idx == 4'(i)) begin
          cells[i] <= digit_in;
        end
      end
    end
  end

  // Checker verdict capture, taken only while the grid is being presented.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      magic    <= 1'b0;
      sum_tens <= '0;
      sum_ones <= '0;
    end else if (clear) begin
      magic    <= 1'b0;
      sum_tens <= '0;
      sum_ones <= '0;
    end else if (take_ack) begin
      magic    <= it_is_magic;
      sum_tens <= sum1;
      sum_ones <= sum2;
    end
  end

  // One-cycle pulse for a dropped out-of-range digit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bad_digit <= 1'b0;
    end else begin
      bad_digit <= reject;
    end
  end

  // Duplicate tracking lives in its own block alongside the seen mask.
  digit_seen_tracker u_seen (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .accept   (store),
    .digit    (digit_in),
    .dup_seen (dup_seen)
  );

  // Parallel view of the grid for the checker.
  always_comb begin
    num1 = cells[0];
    num2 = cells[1];
    num3 = cells[2];
    num4 = cells[3];
    num5 = cells[4];
    num6 = cells[5];
    num7 = cells[6];
    num8 = cells[7];
    num9 = cells[8];
  end

endmodule
